// File: rtl/layer2_pool_buffer_pkg.sv
// Shared LeNet layer-2 constants: sample width, pooled map geometry, and the
// read-side FSM encoding used by the pool buffer.
package layer2_pool_buffer_pkg;

  localparam int L2_DATA_W   = 18;
  localparam int L2_MAP_SIZE = 4;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  function automatic int frame_len(input int map_size);
    return map_size * map_size;
  endfunction

endpackage

// File: rtl/layer2_pool_buffer_if.sv
// Stream bundle between the maxpool stage, the pool buffer and the next layer.
// The master side is the environment; the slave side is the buffer itself.
interface layer2_pool_buffer_if
  import layer2_pool_buffer_pkg::*;
#(
  parameter int DATA_W = L2_DATA_W
);

  logic signed [DATA_W-1:0] pool_data;
  logic                     pool_out;
  logic                     pool_finish;
  logic                     rd_ready;
  logic signed [DATA_W-1:0] dataout;
  logic                     data_valid;
  logic                     frame_last;

  modport master (
    output pool_data, pool_out, pool_finish, rd_ready,
    input  dataout, data_valid, frame_last
  );

  modport slave (
    input  pool_data, pool_out, pool_finish, rd_ready,
    output dataout, data_valid, frame_last
  );

endinterface

// File: rtl/layer2_pool_buffer_bank.sv
// One frame bank: single write port and a registered read port whose output
// register doubles as the buffer's dataout register.
module pool_buf_bank
  import layer2_pool_buffer_pkg::*;
#(
  parameter int DATA_W = L2_DATA_W,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; validity is tracked by bank_full.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer2_pool_buffer.sv
// Ping-pong frame buffer between the layer-2 maxpool stage and the next layer:
// the writer fills one 16-word bank while the reader streams the other in raster order.
module layer2_pool_buffer
  import layer2_pool_buffer_pkg::*;
#(
  parameter int DATA_W   = L2_DATA_W,
  parameter int MAP_SIZE = L2_MAP_SIZE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  layer2_pool_buffer_if.slave bus,
  output logic [1:0]          bank_full,
  output logic                overflow,
  output logic                frame_err
);

  localparam int FRAME_LEN = frame_len(MAP_SIZE);
  localparam int PTR_W     = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);

  logic             wr_bank, rd_bank, rd_bank_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, rd_addr;
  rd_state_t        state, state_nxt;
  logic             data_valid, valid_nxt;
  logic             rd_en, rd_sel, rd_clear;
  logic [1:0]       set_mask, clr_mask;
  logic [DATA_W-1:0] bank_rdata [2];

  // Write-side decode; a full target bank takes priority over a framing error.
  logic write_req, wr_blocked, wr_last, wr_abort, wr_store, wr_commit;
  assign write_req  = enable & bus.pool_out;
  assign wr_blocked = bank_full[wr_bank];
  assign wr_last    = (wr_ptr == LAST_PTR);
  assign wr_abort   = write_req & ~wr_blocked & bus.pool_finish & ~wr_last;
  assign wr_store   = write_req & ~wr_blocked & ~wr_abort;
  assign wr_commit  = wr_store & wr_last;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (write_req & wr_blocked) overflow <= 1'b1;
      if (wr_abort) begin
        frame_err <= 1'b1;
        wr_ptr    <= '0;
      end else if (wr_store) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end

  // NOTE: every comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt   = state;
    valid_nxt   = data_valid;
    rd_ptr_nxt  = rd_ptr;
    rd_bank_nxt = rd_bank;
    rd_en       = 1'b0;
    rd_sel      = rd_bank;
    rd_addr     = rd_ptr;
    rd_clear    = 1'b0;
    if (enable) begin
      unique case (state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) state_nxt = RD_STREAM;
        end
        RD_STREAM: begin
          if (!data_valid) begin
            rd_en     = 1'b1;
            valid_nxt = 1'b1;
          end else if (bus.rd_ready) begin
            if (rd_ptr != LAST_PTR) begin
              rd_en      = 1'b1;
              rd_addr    = rd_ptr + 1'b1;
              rd_ptr_nxt = rd_ptr + 1'b1;
            end else begin
              // Frame done: hand the bank back and chain straight into the other one if ready.
              rd_clear    = 1'b1;
              rd_bank_nxt = ~rd_bank;
              rd_ptr_nxt  = '0;
              if (bank_full[~rd_bank]) begin
                rd_en   = 1'b1;
                rd_sel  = ~rd_bank;
                rd_addr = '0;
              end else begin
                valid_nxt = 1'b0;
                state_nxt = RD_IDLE;
              end
            end
          end
        end
        default: state_nxt = RD_IDLE;
      endcase
    end
  end

  assign set_mask = wr_commit ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = rd_clear  ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RD_IDLE;
      data_valid <= 1'b0;
      rd_ptr     <= '0;
      rd_bank    <= 1'b0;
      bank_full  <= 2'b00;
    end else begin
      state      <= state_nxt;
      data_valid <= valid_nxt;
      rd_ptr     <= rd_ptr_nxt;
      rd_bank    <= rd_bank_nxt;
      bank_full  <= (bank_full | set_mask) & ~clr_mask;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pool_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (FRAME_LEN)
    ) u_bank (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_store & (wr_bank == 1'(b))),
      .waddr   (wr_ptr),
      .wdata   (bus.pool_data),
      .re      (rd_en & (rd_sel == 1'(b))),
      .raddr   (rd_addr),
      .rdata   (bank_rdata[b])
    );
  end

  assign bus.dataout    = bank_rdata[rd_bank];
  assign bus.data_valid = data_valid;
  assign bus.frame_last = data_valid & (rd_ptr == LAST_PTR);

endmodule

// File: tb/tb_layer2_pool_buffer.sv
// Directed bench for layer2_pool_buffer: drives on the falling edge, samples
// on the falling edge, and compares against hand-computed frames.
module tb_layer2_pool_buffer;
  import layer2_pool_buffer_pkg::*;

  localparam int DW = L2_DATA_W;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] bank_full;
  logic       overflow;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int vals [16];

  layer2_pool_buffer_if #(.DATA_W(DW)) bus ();

  layer2_pool_buffer #(
    .DATA_W   (DW),
    .MAP_SIZE (L2_MAP_SIZE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .bus       (bus),
    .bank_full (bank_full),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic write_word(input int v, input bit fin);
    bus.pool_data   = DW'(v);
    bus.pool_out    = 1'b1;
    bus.pool_finish = fin;
    cyc();
    bus.pool_out    = 1'b0;
    bus.pool_finish = 1'b0;
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < 16; i++) vals[i] = base + i;
  endtask

  task automatic write_frame();
    for (int i = 0; i < 16; i++) write_word(vals[i], i == 15);
  endtask

  task automatic read_frame(input string tag);
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 32'(bus.data_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, k), 32'(bus.dataout), vals[k]);
      check($sformatf("%s_last%0d", tag, k), 32'(bus.frame_last), 32'(k == 15));
      cyc();
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && bus.data_valid !== 1'b1; i++) cyc();
    check(tag, 32'(bus.data_valid), 32'd1);
  endtask

  initial begin
    bus.pool_data   = '0;
    bus.pool_out    = 1'b0;
    bus.pool_finish = 1'b0;
    bus.rd_ready    = 1'b0;
    enable          = 1'b1;
    cyc();
    cyc();

    // Reset state
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_last", 32'(bus.frame_last), 32'd0);
    check("rst_data", 32'(bus.dataout), 32'd0);
    check("rst_full", 32'(bank_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Single frame -8..7, reader always ready, two-cycle latency
    bus.rd_ready = 1'b1;
    fill_ramp(-8);
    write_frame();
    check("t1_full", 32'(bank_full), 32'd1);
    check("t1_lat0", 32'(bus.data_valid), 32'd0);
    cyc();
    check("t1_lat1", 32'(bus.data_valid), 32'd0);
    cyc();
    read_frame("t1");
    check("t1_idle", 32'(bus.data_valid), 32'd0);
    check("t1_empty", 32'(bank_full), 32'd0);

    // 33 writes with reader stalled: both banks fill, word 32 dropped
    bus.rd_ready = 1'b0;
    fill_ramp(0);
    write_frame();
    fill_ramp(16);
    write_frame();
    write_word(32, 1'b0);
    check("t2_full", 32'(bank_full), 32'd3);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_valid", 32'(bus.data_valid), 32'd1);
    check("t2_hold", 32'(bus.dataout), 32'd0);
    fill_ramp(0);
    read_frame("t2a");
    fill_ramp(16);
    read_frame("t2b");
    check("t2_idle", 32'(bus.data_valid), 32'd0);
    check("t2_empty", 32'(bank_full), 32'd0);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);

    // rd_ready toggling every cycle
    bus.rd_ready = 1'b0;
    fill_ramp(20);
    write_frame();
    wait_valid("t3_wait", 8);
    for (int k = 0; k < 16; k++) begin
      bus.rd_ready = 1'b0;
      cyc();
      check($sformatf("t3_valid%0d", k), 32'(bus.data_valid), 32'd1);
      check($sformatf("t3_data%0d", k), 32'(bus.dataout), 32'(20 + k));
      check($sformatf("t3_last%0d", k), 32'(bus.frame_last), 32'(k == 15));
      bus.rd_ready = 1'b1;
      cyc();
    end
    check("t3_idle", 32'(bus.data_valid), 32'd0);

    // Early pool_finish discards the partial frame
    for (int i = 0; i < 5; i++) write_word(50 + i, i == 4);
    check("t4_ferr", 32'(frame_err), 32'd1);
    check("t4_empty", 32'(bank_full), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("t4_novalid%0d", i), 32'(bus.data_valid), 32'd0);
    end
    fill_ramp(100);
    write_frame();
    wait_valid("t4_wait", 8);
    read_frame("t4");
    check("t4_ferr_sticky", 32'(frame_err), 32'd1);

    // Freeze mid-stream, then asynchronous reset mid-stream
    fill_ramp(200);
    write_frame();
    wait_valid("t5_wait", 8);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5_data%0d", k), 32'(bus.dataout), 32'(200 + k));
      cyc();
    end
    enable        = 1'b0;
    bus.pool_out  = 1'b1;
    bus.pool_data = DW'(77);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("t5_frz_data%0d", i), 32'(bus.dataout), 32'd203);
      check($sformatf("t5_frz_valid%0d", i), 32'(bus.data_valid), 32'd1);
      check($sformatf("t5_frz_last%0d", i), 32'(bus.frame_last), 32'd0);
      check($sformatf("t5_frz_full%0d", i), 32'(bank_full), 32'd2);
    end
    bus.pool_out = 1'b0;
    enable       = 1'b1;
    cyc();
    check("t5_resume", 32'(bus.dataout), 32'd204);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.data_valid), 32'd0);
    check("t5_rst_last", 32'(bus.frame_last), 32'd0);
    check("t5_rst_data", 32'(bus.dataout), 32'd0);
    check("t5_rst_full", 32'(bank_full), 32'd0);
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    check("t5_rst_ferr", 32'(frame_err), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    check("t5_post_idle", 32'(bus.data_valid), 32'd0);

    // Full-scale signed extremes pass bit-exact
    fill_ramp(0);
    vals[0]  = -131072;
    vals[1]  = 131071;
    vals[15] = -1;
    write_frame();
    wait_valid("t6_wait", 8);
    read_frame("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer2_pool_buffer.md
LAYER2_POOL_BUFFER -- requirements
Module: layer2_pool_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 18, sample width (signed two's complement).
REQ-002 SHALL have parameter MAP_SIZE, default 4, pooled map side; frame = MAP_SIZE*MAP_SIZE = 16 words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  global clock enable; low freezes all state.
REQ-006 SHALL have port pool_data  input  DATA_W  signed pooled sample from the maxpool stage.
REQ-007 SHALL have port pool_out  input  1  write strobe; pool_data valid this cycle.
REQ-008 SHALL have port pool_finish  input  1  last-of-frame marker; sampled only when pool_out=1.
REQ-009 SHALL have port rd_ready  input  1  downstream accepts dataout this cycle.
REQ-010 SHALL have port dataout  output  DATA_W  signed raster-order sample to the next layer.
REQ-011 SHALL have port data_valid  output  1  dataout valid.
REQ-012 SHALL have port frame_last  output  1  high with the 16th word of a frame.
REQ-013 SHALL have port bank_full  output  2  per-bank committed-frame flags.
REQ-014 SHALL have port overflow  output  1  sticky; write dropped because target bank was full.
REQ-015 SHALL have port frame_err  output  1  sticky; pool_finish arrived on a write other than the 16th.

Function
REQ-016 SHALL hold two 16-word banks (ping-pong); writer fills wr_bank while reader drains rd_bank.
REQ-017 SHALL ignore all inputs and hold all state and outputs while enable=0.
REQ-018 SHALL, on enable & pool_out with bank_full[wr_bank]=0, store pool_data at wr_ptr and increment wr_ptr.
REQ-019 SHALL, on the write at wr_ptr=15, set bank_full[wr_bank], toggle wr_bank, clear wr_ptr, regardless of pool_finish.
REQ-020 SHALL, on enable & pool_out & pool_finish with wr_ptr!=15, set frame_err, discard the partial frame (wr_ptr to 0, bank stays empty), and not store the word.
REQ-021 SHALL, on enable & pool_out with bank_full[wr_bank]=1 (pre-edge value), drop the word, set overflow, leave wr_ptr unchanged.
REQ-022 SHALL implement read FSM IDLE -> STREAM when bank_full[rd_bank]=1; data_valid=1 with dataout=word 0 at the next edge.
REQ-023 SHALL, in STREAM, transfer a word on enable & data_valid & rd_ready, then advance rd_ptr; dataout/data_valid stay stable while rd_ready=0.
REQ-024 SHALL assert frame_last exactly when data_valid=1 and rd_ptr=15.
REQ-025 SHALL, on the transfer at rd_ptr=15, clear bank_full[rd_bank], toggle rd_bank, clear rd_ptr; stay in STREAM with no bubble if the other bank is full, else go IDLE with data_valid=0.
REQ-026 SHALL apply a same-cycle set of one bank_full bit and clear of the other both.
REQ-027 SHALL pass data bit-exact (no rounding, saturation or sign change).
REQ-028 SHALL give 2-cycle latency from a committing write (edge N) to data_valid=1 (edge N+2) when reader is idle.

Reset
REQ-029 SHALL, on reset_n=0, asynchronously force dataout=0, data_valid=0, frame_last=0, bank_full=00, overflow=0, frame_err=0, wr_ptr=rd_ptr=0, wr_bank=rd_bank=0, FSM=IDLE.
REQ-030 SHALL NOT reset bank memory contents; reset mid-frame discards all buffered data.
REQ-031 SHALL clear overflow and frame_err only by reset.

Structure
REQ-032 SHALL take DATA_W, MAP_SIZE, frame length and FSM state encoding from the shared LeNet constants package.
REQ-033 SHALL instantiate sub-module pool_buf_bank (16xDATA_W, one write port, one registered read port) twice.

Verification
REQ-034 SHALL cover: reset, 16 writes -8..7 with pool_finish on 16th, rd_ready=1 -> 16 consecutive valid words -8..7, frame_last on 7, bank_full 00 after.
REQ-035 SHALL cover: rd_ready=0, 33 writes 0..32 -> bank_full=11, word 32 dropped, overflow=1; then rd_ready=1 -> 0..31 back-to-back, frame_last on 15 and 31.
REQ-036 SHALL cover: rd_ready toggling every cycle -> dataout stable while unaccepted, sequence intact.
REQ-037 SHALL cover: pool_finish on 5th write -> frame_err=1, no data_valid; next clean frame 100..115 streams correctly.
REQ-038 SHALL cover: enable=0 for 3 cycles mid-stream -> outputs frozen; then reset_n=0 mid-stream -> data_valid=0 immediately, bank_full=00, flags 0.
REQ-039 SHALL cover: words -131072 and 131071 -> output bit-exact.
